// File: rtl/clock_divider_multi.sv
// Multi-channel programmable clock divider with glitch-free divisor reload.
// Define CLOCK_DIVIDER_SYNC_EN to add the sync_in phase-realign input.
module clock_divider_multi #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 25,
  parameter int DEFAULT_DIV = 12500000,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic [NUM_CH-1:0] en,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [CNT_W-1:0]  wr_div,
`ifdef CLOCK_DIVIDER_SYNC_EN
  input  logic              sync_in,
`endif
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);

  logic [CNT_W-1:0]  cnt_q    [NUM_CH];
  logic [CNT_W-1:0]  cnt_d    [NUM_CH];
  logic [CNT_W-1:0]  shadow_q [NUM_CH];
  logic [CNT_W-1:0]  shadow_d [NUM_CH];
  logic [CNT_W-1:0]  active_q [NUM_CH];
  logic [CNT_W-1:0]  active_d [NUM_CH];
  logic [NUM_CH-1:0] clk_q;
  logic [NUM_CH-1:0] clk_d;
  logic [NUM_CH-1:0] tick_q;
  logic [NUM_CH-1:0] tick_d;
  logic              sync_w;

`ifdef CLOCK_DIVIDER_SYNC_EN
  assign sync_w = sync_in;
`else
  assign sync_w = 1'b0;
`endif

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      cnt_d[c]    = cnt_q[c] + CNT_W'(1);
      clk_d[c]    = clk_q[c];
      tick_d[c]   = 1'b0;
      active_d[c] = active_q[c];
      shadow_d[c] = shadow_q[c];
      // hold/realign beats terminal count; both reload from shadow
      if (!en[c] || sync_w) begin
        cnt_d[c]    = '0;
        clk_d[c]    = 1'b0;
        active_d[c] = shadow_q[c];
      end else if (cnt_q[c] >= active_q[c]) begin
        cnt_d[c]    = '0;
        clk_d[c]    = ~clk_q[c];
        tick_d[c]   = 1'b1;
        active_d[c] = shadow_q[c];
      end
      if (wr_en && (wr_ch == CH_W'(c))) begin
        shadow_d[c] = wr_div;
      end
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        cnt_q[c]    <= '0;
        shadow_q[c] <= DIV_RST;
        active_q[c] <= DIV_RST;
      end
      clk_q  <= '0;
      tick_q <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        cnt_q[c]    <= cnt_d[c];
        shadow_q[c] <= shadow_d[c];
        active_q[c] <= active_d[c];
      end
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

  assign clk_out = clk_q;
  assign tick    = tick_q;

endmodule

// File: tb/tb_clock_divider_multi.sv
// Bench for clock_divider_multi: vector table, corner sequences, random vs model.
// Covers the sync_in sequence when CLOCK_DIVIDER_SYNC_EN is defined.
module tb_clock_divider_multi;

  localparam int NC  = 3;
  localparam int CW  = 8;
  localparam int DEF = 3;

`ifdef CLOCK_DIVIDER_SYNC_EN
  localparam bit HAS_SYNC = 1'b1;
`else
  localparam bit HAS_SYNC = 1'b0;
`endif

  logic          clk_in = 1'b0;
  logic          reset;
  logic [NC-1:0] en;
  logic          wr_en;
  logic [1:0]    wr_ch;
  logic [CW-1:0] wr_div;
  logic          sync_in;
  logic [NC-1:0] clk_out;
  logic [NC-1:0] tick;

  int checks = 0;
  int errors = 0;

  clock_divider_multi #(
    .NUM_CH(NC), .CNT_W(CW), .DEFAULT_DIV(DEF)
  ) dut (
    .clk_in (clk_in),
    .reset  (reset),
    .en     (en),
    .wr_en  (wr_en),
    .wr_ch  (wr_ch),
    .wr_div (wr_div),
`ifdef CLOCK_DIVIDER_SYNC_EN
    .sync_in(sync_in),
`endif
    .clk_out(clk_out),
    .tick   (tick)
  );

  always #5 clk_in = ~clk_in;

  // Reference: countdown of cycles left in the current half-period.
  int m_shd [NC];
  int m_cur [NC];
  int m_rem [NC];
  bit m_lvl [NC];
  bit m_tck [NC];

  function automatic void model_reset();
    for (int c = 0; c < NC; c++) begin
      m_shd[c] = DEF;
      m_cur[c] = DEF;
      m_rem[c] = DEF + 1;
      m_lvl[c] = 1'b0;
      m_tck[c] = 1'b0;
    end
  endfunction

  function automatic void model_step(
    input logic [NC-1:0] e, input logic we,
    input logic [1:0] wc, input logic [CW-1:0] wd,
    input logic sy);
    for (int c = 0; c < NC; c++) begin
      if (!e[c] || sy) begin
        m_lvl[c] = 1'b0;
        m_tck[c] = 1'b0;
        m_cur[c] = m_shd[c];
        m_rem[c] = m_cur[c] + 1;
      end else begin
        m_rem[c] = m_rem[c] - 1;
        m_tck[c] = (m_rem[c] == 0);
        if (m_rem[c] == 0) begin
          m_lvl[c] = ~m_lvl[c];
          m_cur[c] = m_shd[c];
          m_rem[c] = m_cur[c] + 1;
        end
      end
    end
    if (we && int'(wc) < NC) m_shd[wc] = int'(wd);
  endfunction

  function automatic logic [NC-1:0] m_clk();
    logic [NC-1:0] v;
    for (int c = 0; c < NC; c++) v[c] = m_lvl[c];
    return v;
  endfunction

  function automatic logic [NC-1:0] m_tick();
    logic [NC-1:0] v;
    for (int c = 0; c < NC; c++) v[c] = m_tck[c];
    return v;
  endfunction

  task automatic check(input string nm,
    input logic [NC-1:0] ac, input logic [NC-1:0] ec,
    input logic [NC-1:0] at, input logic [NC-1:0] et);
    checks++;
    if (ac !== ec || at !== et) begin
      errors++;
      $display("FAIL %s t=%0t: clk_out=%b tick=%b expected clk_out=%b tick=%b",
               nm, $time, ac, at, ec, et);
    end
  endtask

  task automatic step(input logic [NC-1:0] e, input logic we,
    input logic [1:0] wc, input logic [CW-1:0] wd, input logic sy);
    logic s;
    s = sy & HAS_SYNC;
    en = e; wr_en = we; wr_ch = wc; wr_div = wd; sync_in = s;
    @(posedge clk_in);
    model_step(e, we, wc, wd, s);
    #1;
    check("model", clk_out, m_clk(), tick, m_tick());
  endtask

  typedef struct {
    logic [NC-1:0] en;
    logic          we;
    logic [1:0]    wc;
    logic [CW-1:0] wd;
    logic [NC-1:0] clk;
    logic [NC-1:0] tk;
  } vec_t;

  vec_t tbl [20];

  initial begin
    tbl[0]  = '{3'b011, 1'b0, 2'd0, 8'd0, 3'b000, 3'b000};
    tbl[1]  = '{3'b011, 1'b0, 2'd0, 8'd0, 3'b000, 3'b000};
    tbl[2]  = '{3'b011, 1'b0, 2'd0, 8'd0, 3'b000, 3'b000};
    tbl[3]  = '{3'b011, 1'b0, 2'd0, 8'd0, 3'b011, 3'b011};
    tbl[4]  = '{3'b011, 1'b0, 2'd0, 8'd0, 3'b011, 3'b000};
    tbl[5]  = '{3'b011, 1'b0, 2'd0, 8'd0, 3'b011, 3'b000};
    tbl[6]  = '{3'b011, 1'b0, 2'd0, 8'd0, 3'b011, 3'b000};
    tbl[7]  = '{3'b011, 1'b0, 2'd0, 8'd0, 3'b000, 3'b011};
    tbl[8]  = '{3'b011, 1'b1, 2'd1, 8'd0, 3'b000, 3'b000};
    tbl[9]  = '{3'b011, 1'b0, 2'd0, 8'd0, 3'b000, 3'b000};
    tbl[10] = '{3'b011, 1'b0, 2'd0, 8'd0, 3'b000, 3'b000};
    tbl[11] = '{3'b011, 1'b0, 2'd0, 8'd0, 3'b011, 3'b011};
    tbl[12] = '{3'b011, 1'b0, 2'd0, 8'd0, 3'b001, 3'b010};
    tbl[13] = '{3'b011, 1'b0, 2'd0, 8'd0, 3'b011, 3'b010};
    tbl[14] = '{3'b011, 1'b0, 2'd0, 8'd0, 3'b001, 3'b010};
    tbl[15] = '{3'b011, 1'b0, 2'd0, 8'd0, 3'b010, 3'b011};
    tbl[16] = '{3'b011, 1'b1, 2'd3, 8'd7, 3'b000, 3'b010};
    tbl[17] = '{3'b011, 1'b0, 2'd0, 8'd0, 3'b010, 3'b010};
    tbl[18] = '{3'b011, 1'b0, 2'd0, 8'd0, 3'b000, 3'b010};
    tbl[19] = '{3'b011, 1'b0, 2'd0, 8'd0, 3'b011, 3'b011};

    reset = 1'b0; en = '0; wr_en = 1'b0;
    wr_ch = '0; wr_div = '0; sync_in = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_in);
    #1;
    check("reset_state", clk_out, '0, tick, '0);
    #3 reset = 1'b1;

    // default period, div=0 write mid half-period, out-of-range write
    for (int i = 0; i < 20; i++) begin
      step(tbl[i].en, tbl[i].we, tbl[i].wc, tbl[i].wd, 1'b0);
      check($sformatf("vec%0d", i), clk_out, tbl[i].clk,
            tick, tbl[i].tk);
    end

    // drop en[0] for 5 cycles mid-count
    step(3'b011, 1'b0, 2'd0, 8'd0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step(3'b010, 1'b0, 2'd0, 8'd0, 1'b0);
      check("en_drop", {2'b0, clk_out[0]}, '0, {2'b0, tick[0]}, '0);
    end
    for (int k = 1; k <= 4; k++) begin
      step(3'b011, 1'b0, 2'd0, 8'd0, 1'b0);
      check("en_restart", {2'b0, clk_out[0]}, {2'b0, k == 4},
            {2'b0, tick[0]}, {2'b0, k == 4});
    end

    // async reset mid-count after writing div=9
    step(3'b011, 1'b1, 2'd0, 8'd9, 1'b0);
    step(3'b011, 1'b0, 2'd0, 8'd0, 1'b0);
    step(3'b011, 1'b0, 2'd0, 8'd0, 1'b0);
    #2 reset = 1'b0;
    #1;
    check("reset_async", clk_out, '0, tick, '0);
    model_reset();
    @(posedge clk_in);
    #3 reset = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step(3'b011, 1'b0, 2'd0, 8'd0, 1'b0);
      check("post_reset", {1'b0, clk_out[1:0]},
            (k >= 4 && k < 8) ? 3'b011 : 3'b000,
            {1'b0, tick[1:0]},
            (k == 4 || k == 8) ? 3'b011 : 3'b000);
    end

`ifdef CLOCK_DIVIDER_SYNC_EN
    step(3'b011, 1'b1, 2'd1, 8'd1, 1'b0);
    step(3'b000, 1'b0, 2'd0, 8'd0, 1'b0);
    repeat (3) step(3'b011, 1'b0, 2'd0, 8'd0, 1'b0);
    step(3'b011, 1'b0, 2'd0, 8'd0, 1'b1);
    check("sync_clear", clk_out, '0, tick, '0);
    for (int k = 1; k <= 4; k++) begin
      step(3'b011, 1'b0, 2'd0, 8'd0, 1'b0);
      check("sync_realign", {1'b0, clk_out[1:0]},
            {1'b0, k == 2 || k == 3, k == 4},
            {1'b0, tick[1:0]},
            {1'b0, k == 2 || k == 4, k == 4});
    end
`endif

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic [NC-1:0] e;
      e = en;
      if ($urandom_range(15) == 0) e[$urandom_range(NC - 1)] ^= 1'b1;
      step(e, $urandom_range(7) == 0, 2'($urandom_range(3)),
           8'($urandom_range(5)), $urandom_range(31) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
